ofmap_accumulator: RTL

Output-side collector for one systolic-array column. It consumes the partial-sum stream (`MAC_valid_in`/`MAC_data_in`) leaving the bottom MAC PE. Over one or more K-tile passes it accumulates that stream into a DEPTH-entry buffer. After the last pass it drains the finished ofmap values through a valid/ready port toward the output SRAM writer.

---
 rtl/ofmap_accumulator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ofmap_accumulator.sv
// ofmap_accumulator: collects the partial-sum stream from the bottom PE of one
// systolic-array column. Over one or more K-tile passes it accumulates the
// stream into a DEPTH-entry buffer. After the last pass it drains the finished
// ofmap values through a valid/ready port.
module ofmap_accumulator #(
  parameter int OFMAP_BITWIDTH = 32,
  parameter int ACC_BITWIDTH   = 32,
  parameter int DEPTH          = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tile_start_in,
  input  logic                      tile_first_in,
  input  logic                      tile_last_in,
  input  logic                      MAC_valid_in,
  input  logic [OFMAP_BITWIDTH-1:0] MAC_data_in,
  output logic                      ofmap_valid_out,
  output logic [ACC_BITWIDTH-1:0]   ofmap_data_out,
  input  logic                      ofmap_ready_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      sat_out,
  output logic                      err_out
);

  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
  localparam int              A        = ACC_BITWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_first, r_last;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [A-1:0]    r_buf [DEPTH];
  logic            r_valid, r_done, r_sat, r_err;
  logic [A-1:0]    r_data;

  logic            w_start, w_wr_en, w_pass_end, w_xfer, w_drain_end, w_done_nxt;
  logic [A-1:0]    w_x, w_old, w_acc, w_clamp, w_wdata;
  logic [A:0]      w_sum;
  logic            w_ovf, w_sat_hit;

  // Handshake / event decode
  assign w_start     = (r_state == S_IDLE) && tile_start_in;
  assign w_wr_en     = (r_state == S_ACCUM) && MAC_valid_in;
  assign w_pass_end  = w_wr_en && (r_wr_ptr == LAST_IDX);
  assign w_xfer      = (r_state == S_DRAIN) && r_valid && ofmap_ready_in;
  assign w_drain_end = w_xfer && (r_rd_ptr == LAST_IDX);

  // Sign-extended partial sum and saturating add at A+1 bits.
  // Overflow shows up as disagreement between the two top sum bits;
  // the extra top bit carries the true sign, which picks the clamp direction.
  assign w_x       = A'($signed(MAC_data_in));
  assign w_old     = r_buf[r_wr_ptr];
  assign w_sum     = {w_old[A-1], w_old} + {w_x[A-1], w_x};
  assign w_ovf     = w_sum[A] ^ w_sum[A-1];
  assign w_clamp   = w_sum[A] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}};
  assign w_acc     = w_ovf ? w_clamp : w_sum[A-1:0];
  assign w_wdata   = r_first ? w_x : w_acc;
  assign w_sat_hit = w_wr_en && !r_first && w_ovf;

  // Next-state and completion-pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  if (tile_start_in) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_pass_end) begin
                 w_state_nxt = r_last ? S_DRAIN : S_IDLE;
                 w_done_nxt  = !r_last;
               end
      S_DRAIN: if (w_drain_end) begin
                 w_state_nxt = S_IDLE;
                 w_done_nxt  = 1'b1;
               end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, pointers, pass flags, sticky status and registered drain port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_done   <= 1'b0;
      r_sat    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;

      if (w_start) begin
        r_first  <= tile_first_in;
        r_last   <= tile_last_in;
        r_wr_ptr <= '0;
        if (tile_first_in) r_sat <= 1'b0;
      end

      if (w_wr_en)
        r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PW'(1);
      if (w_sat_hit) r_sat <= 1'b1;

      // Stream data arriving while not accumulating is dropped and flagged
      if (MAC_valid_in && (r_state != S_ACCUM)) r_err <= 1'b1;

      // Entry 0 is never the one written on the final edge (DEPTH >= 2),
      // so it can be preloaded into the output register directly.
      if (w_pass_end && r_last) begin
        r_rd_ptr <= '0;
        r_valid  <= 1'b1;
        r_data   <= r_buf[0];
      end

      // Output register only advances on a transfer, so data holds under backpressure
      if (w_xfer) begin
        if (w_drain_end) begin
          r_rd_ptr <= '0;
          r_valid  <= 1'b0;
          r_data   <= '0;
        end else begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
          r_data   <= r_buf[r_rd_ptr + PW'(1)];
        end
      end
    end
  end

  // Accumulation buffer: cleared on reset, written once per accepted partial sum
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_wr_en) begin
      r_buf[r_wr_ptr] <= w_wdata;
    end
  end

  assign ofmap_valid_out = r_valid;
  assign ofmap_data_out  = r_data;
  assign busy_out        = (r_state != S_IDLE);
  assign done_out        = r_done;
  assign sat_out         = r_sat;
  assign err_out         = r_err;

endmodule
